// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch unit memory request/response and decode-side handshake bundle
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - single-outstanding instruction fetch FSM with redirect/flush; optional PC_MISALIGN_CHECK_EN
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc_in,
    input  logic            redirect,
    input  logic            stall,
    output logic            misaligned,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FLUSH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic            req_valid;
    logic            out_valid;
    logic            redir_ok;

`ifdef PC_MISALIGN_CHECK_EN
    logic redir_bad;

    // A redirect to a non-word address is dropped and flagged in the same cycle.
    assign redir_bad  = redirect && (next_pc_in[1:0] != 2'b00);
    assign redir_ok   = redirect && !redir_bad;
    assign misaligned = redir_bad && !rst;
`else
    assign redir_ok   = redirect;
    assign misaligned = 1'b0;
`endif

    // Outputs are masked during reset so nothing handshakes while state is being cleared.
    assign bus.imem_req_valid = req_valid && !rst;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = out_valid && !rst;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instr       = if_instr_q;

    // State, PC and captured instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // Next-state, PC update and handshake outputs; redirect outranks stall and if_ready.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        req_valid  = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                req_valid = !stall;
                if (redir_ok) begin
                    // A request already on the bus this cycle leaves a response to throw away.
                    pc_d    = next_pc_in;
                    state_d = (req_valid && bus.imem_req_ready) ? FLUSH : REQ;
                end else if (req_valid && bus.imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redir_ok) begin
                    pc_d    = next_pc_in;
                    state_d = bus.imem_resp_valid ? REQ : FLUSH;
                end else if (bus.imem_resp_valid) begin
                    if_instr_d = bus.imem_resp_data;
                    if_pc_d    = pc_q;
                    state_d    = HOLD;
                end
            end
            FLUSH: begin
                if (redir_ok) begin
                    pc_d = next_pc_in;
                end
                if (bus.imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (redir_ok) begin
                    // The held instruction is on the wrong path; do not count it as consumed.
                    pc_d    = next_pc_in;
                    state_d = REQ;
                end else if (bus.if_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc_in;
    logic        redirect;
    logic        stall;
    logic        misaligned;
    int          errors;
    int          checks;

    pc_fetch_unit_if #(.XLEN(32)) bus ();

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc_in (next_pc_in),
        .redirect   (redirect),
        .stall      (stall),
        .misaligned (misaligned),
        .bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic [31:0] prev_addr;
    logic        outstanding;
    logic        prev_fire;
    int          delay;
    int          transfers;
    int          n;

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; next_pc_in = '0; redirect = 1'b0; stall = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = '0; bus.if_ready = 1'b0;
        tick(); tick();
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_if_pc", bus.if_pc, 0);
        chk("rst_if_instr", bus.if_instr, 0);
        chk("rst_misaligned", misaligned, 0);

        // Basic fetch from RESET_PC
        rst = 1'b0; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1; #1;
        n = 0;
        while (!bus.imem_req_valid && n < 20) begin tick(); n++; end
        chk("first_req_valid", bus.imem_req_valid, 1);
        chk("first_req_addr", bus.imem_req_addr, 32'h100);
        tick();
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0013; #1;
        tick();
        bus.imem_resp_valid = 1'b0; #1;
        chk("first_if_valid", bus.if_valid, 1);
        chk("first_if_pc", bus.if_pc, 32'h100);
        chk("first_if_instr", bus.if_instr, 32'h13);
        tick();
        chk("second_req_addr", bus.imem_req_addr, 32'h104);

        // Hold stability with if_ready low
        bus.if_ready = 1'b0; tick();
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hAAAA_0001; #1;
        tick();
        bus.imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_if_valid", bus.if_valid, 1);
            chk("hold_if_pc", bus.if_pc, 32'h104);
            chk("hold_if_instr", bus.if_instr, 32'hAAAA_0001);
            chk("hold_no_req", bus.imem_req_valid, 0);
            tick();
        end
        bus.if_ready = 1'b1; #1;
        tick();
        bus.if_ready = 1'b0; #1;
        chk("after_hold_if_valid", bus.if_valid, 0);
        chk("after_hold_req_valid", bus.imem_req_valid, 1);
        chk("after_hold_req_addr", bus.imem_req_addr, 32'h108);

        // Redirect in WAIT, stale response dropped in FLUSH
        tick();
        redirect = 1'b1; next_pc_in = 32'h200; #1;
        tick();
        redirect = 1'b0; #1;
        chk("flush_no_req", bus.imem_req_valid, 0);
        tick();
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hDEAD_BEEF; #1;
        chk("flush_if_valid", bus.if_valid, 0);
        tick();
        bus.imem_resp_valid = 1'b0; #1;
        chk("stale_if_valid", bus.if_valid, 0);
        chk("redir200_req_addr", bus.imem_req_addr, 32'h200);

        // Redirect coinciding with response in WAIT
        tick();
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h55; redirect = 1'b1; next_pc_in = 32'h300; #1;
        tick();
        bus.imem_resp_valid = 1'b0; redirect = 1'b0; #1;
        chk("same_cycle_if_valid", bus.if_valid, 0);
        chk("redir300_req_addr", bus.imem_req_addr, 32'h300);

        // Stall blocks the request
        stall = 1'b1; #1;
        chk("stall_req_valid", bus.imem_req_valid, 0);
        tick();
        stall = 1'b0;

        // Redirect in REQ without transfer, then PC wrap
        bus.imem_req_ready = 1'b0; redirect = 1'b1; next_pc_in = 32'hFFFF_FFFC; #1;
        tick();
        redirect = 1'b0; bus.imem_req_ready = 1'b1; #1;
        chk("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        tick();
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h11; #1;
        tick();
        bus.imem_resp_valid = 1'b0; #1;
        chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        bus.if_ready = 1'b1; #1;
        tick();
        bus.if_ready = 1'b0; #1;
        chk("wrapped_req_addr", bus.imem_req_addr, 32'h0);

        // Redirect in HOLD while if_ready is high
        tick();
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h22; #1;
        tick();
        bus.imem_resp_valid = 1'b0; bus.if_ready = 1'b1; redirect = 1'b1; next_pc_in = 32'h400; #1;
        chk("hold_redir_if_valid", bus.if_valid, 1);
        tick();
        redirect = 1'b0; bus.if_ready = 1'b0; #1;
        chk("hold_redir_dropped", bus.if_valid, 0);
        chk("redir400_req_addr", bus.imem_req_addr, 32'h400);

        // Misaligned redirect
        bus.imem_req_ready = 1'b0; redirect = 1'b1; next_pc_in = 32'h202; #1;
`ifdef PC_MISALIGN_CHECK_EN
        chk("misaligned_pulse", misaligned, 1);
`else
        chk("misaligned_tied", misaligned, 0);
`endif
        tick();
        redirect = 1'b0; bus.imem_req_ready = 1'b1; #1;
        chk("misaligned_low", misaligned, 0);
`ifdef PC_MISALIGN_CHECK_EN
        chk("misaligned_pc_kept", bus.imem_req_addr, 32'h400);
`else
        chk("misaligned_loaded", bus.imem_req_addr, 32'h202);
`endif

        // Reset with a request outstanding; late response ignored
        tick();
        rst = 1'b1; #1;
        tick();
        rst = 1'b0; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h77; #1;
        tick();
        bus.imem_resp_valid = 1'b0; #1;
        chk("post_rst_if_valid", bus.if_valid, 0);
        chk("post_rst_if_instr", bus.if_instr, 0);
        chk("post_rst_req_addr", bus.imem_req_addr, 32'h100);

        // Randomized traffic: delivered instructions must form the architectural stream
        exp_pc = 32'h100; outstanding = 1'b0; prev_fire = 1'b0; prev_addr = '0;
        pend_addr = '0; delay = 0; transfers = 0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.imem_resp_valid) begin
                outstanding = 1'b0;
                bus.imem_resp_valid = 1'b0;
            end
            if (prev_fire) begin
                outstanding = 1'b1;
                pend_addr = prev_addr;
                delay = int'($urandom_range(0, 2));
            end
            if (outstanding) begin
                if (delay == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data = mem_word(pend_addr);
                end else begin
                    delay--;
                end
            end
            bus.imem_req_ready = ($urandom % 4) != 0;
            stall = ($urandom % 5) == 0;
            bus.if_ready = ($urandom % 3) != 0;
            redirect = ($urandom % 12) == 0;
            next_pc_in = $urandom & 32'hFFFF_FFFC;
            #1;
            chk("rand_misaligned", misaligned, 0);
            if (bus.imem_req_valid)
                chk("rand_one_outstanding", outstanding, 0);
            if (bus.if_valid && bus.if_ready && !redirect) begin
                chk("rand_if_pc", bus.if_pc, exp_pc);
                chk("rand_if_instr", bus.if_instr, mem_word(bus.if_pc));
                exp_pc = bus.if_pc + 32'd4;
                transfers++;
            end
            if (redirect)
                exp_pc = next_pc_in;
            prev_fire = bus.imem_req_valid && bus.imem_req_ready;
            prev_addr = bus.imem_req_addr;
            tick();
        end
        chk("rand_progress", (transfers >= 50) ? 32'd1 : 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
